// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready bundle for one side of an elastic pipeline stage.
// The master drives the payload and valid; the slave drives ready.
interface pipe_stage_elastic_if #(
  parameter int CTRL_WIDTH = 8,
  parameter int DATA_WIDTH = 64,
  parameter int SEL_WIDTH  = 3
);
  logic                  valid;
  logic                  ready;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic [DATA_WIDTH-1:0] data;
  logic [SEL_WIDTH-1:0]  sel;

  modport master (
    output valid,
    output ctrl,
    output data,
    output sel,
    input  ready
  );

  modport slave (
    input  valid,
    input  ctrl,
    input  data,
    input  sel,
    output ready
  );
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register with stall, flush and optional skid.
// Empty slots carry all-zero control so downstream sees a NOP.
module pipe_stage_elastic #(
  parameter int CTRL_WIDTH = 8,
  parameter int DATA_WIDTH = 64,
  parameter int SEL_WIDTH  = 3,
  parameter int SKID       = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  pipe_stage_elastic_if.slave  up,
  pipe_stage_elastic_if.master dn,
  output logic [1:0]           occupancy
);

  typedef struct packed {
    logic [CTRL_WIDTH-1:0] ctrl;
    logic [DATA_WIDTH-1:0] data;
    logic [SEL_WIDTH-1:0]  sel;
  } ent_t;

  ent_t m_q;
  ent_t s_q;
  ent_t in_e;
  logic m_valid;
  logic s_valid;
  logic in_ready;
  logic in_fire;
  logic m_free;

  assign in_e = {up.ctrl, up.data, up.sel};

  // With skid, ready comes straight from a flop and breaks the
  // combinational ready chain through the pipeline.
  if (SKID != 0) begin : g_skid
    assign in_ready = ~s_valid;
  end else begin : g_reg
    assign in_ready = ~m_valid | dn.ready;
  end

  assign in_fire = up.valid & in_ready;
  assign m_free  = ~m_valid | dn.ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_q     <= '0;
      s_q     <= '0;
    end else if (flush) begin
      m_valid    <= 1'b0;
      s_valid    <= 1'b0;
      m_q.ctrl   <= '0;
      s_q.ctrl   <= '0;
    end else if (m_free) begin
      if (s_valid) begin
        m_q      <= s_q;
        m_valid  <= 1'b1;
        s_valid  <= 1'b0;
        s_q.ctrl <= '0;
      end else if (in_fire) begin
        m_q     <= in_e;
        m_valid <= 1'b1;
      end else begin
        m_valid  <= 1'b0;
        m_q.ctrl <= '0;
      end
    end else if (in_fire) begin
      // Only reachable with skid: M is stalled, park the entry in S.
      s_q     <= in_e;
      s_valid <= 1'b1;
    end
  end

  assign up.ready  = in_ready;
  assign dn.valid  = m_valid;
  assign dn.ctrl   = m_q.ctrl;
  assign dn.data   = m_q.data;
  assign dn.sel    = m_q.sel;
  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: directed tables for both SKID modes,
// then random valid/ready/flush against a FIFO reference model.
module tb_pipe_stage_elastic;
  localparam int CW = 8;
  localparam int DW = 16;
  localparam int SW = 3;

  typedef struct {
    logic          rst;
    logic          flush;
    logic          iv;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic          rdy;
    logic          e_ov;
    logic          e_ir;
    logic [CW-1:0] e_oc;
    logic [DW-1:0] e_od;
    logic [SW-1:0] e_os;
    logic [1:0]    e_occ;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fl  = 1'b0;
  always #5 clk = ~clk;

  logic          iv   [2];
  logic          ordy [2];
  logic [CW-1:0] ic   [2];
  logic [DW-1:0] idt  [2];
  logic [SW-1:0] isl  [2];
  logic          ov   [2];
  logic          ir   [2];
  logic [CW-1:0] oc   [2];
  logic [DW-1:0] od   [2];
  logic [SW-1:0] os   [2];
  logic [1:0]    occ  [2];

  pipe_stage_elastic_if #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW),
    .SEL_WIDTH(SW)) up0 ();
  pipe_stage_elastic_if #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW),
    .SEL_WIDTH(SW)) dn0 ();
  pipe_stage_elastic_if #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW),
    .SEL_WIDTH(SW)) up1 ();
  pipe_stage_elastic_if #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW),
    .SEL_WIDTH(SW)) dn1 ();

  assign up0.valid = iv[0];
  assign up0.ctrl  = ic[0];
  assign up0.data  = idt[0];
  assign up0.sel   = isl[0];
  assign dn0.ready = ordy[0];
  assign ir[0]     = up0.ready;
  assign ov[0]     = dn0.valid;
  assign oc[0]     = dn0.ctrl;
  assign od[0]     = dn0.data;
  assign os[0]     = dn0.sel;

  assign up1.valid = iv[1];
  assign up1.ctrl  = ic[1];
  assign up1.data  = idt[1];
  assign up1.sel   = isl[1];
  assign dn1.ready = ordy[1];
  assign ir[1]     = up1.ready;
  assign ov[1]     = dn1.valid;
  assign oc[1]     = dn1.ctrl;
  assign od[1]     = dn1.data;
  assign os[1]     = dn1.sel;

  pipe_stage_elastic #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW),
    .SEL_WIDTH(SW), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .flush(fl),
    .up(up0), .dn(dn0), .occupancy(occ[0])
  );

  pipe_stage_elastic #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW),
    .SEL_WIDTH(SW), .SKID(1)) dut1 (
    .clk(clk), .rst(rst), .flush(fl),
    .up(up1), .dn(dn1), .occupancy(occ[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic r, input logic f, input logic v,
    input logic [CW-1:0] c, input logic [DW-1:0] d,
    input logic [SW-1:0] s, input logic rdy,
    input logic eov, input logic eir,
    input logic [CW-1:0] eoc, input logic [DW-1:0] eod,
    input logic [SW-1:0] eos, input logic [1:0] eocc);
    vec_t t;
    t.rst = r;    t.flush = f;  t.iv = v;
    t.c = c;      t.d = d;      t.s = s;
    t.rdy = rdy;  t.e_ov = eov; t.e_ir = eir;
    t.e_oc = eoc; t.e_od = eod; t.e_os = eos;
    t.e_occ = eocc;
    return t;
  endfunction

  task automatic apply(input int i, input vec_t v, input string tag);
    rst    = v.rst;
    fl     = v.flush;
    iv[i]  = v.iv;
    ic[i]  = v.c;
    idt[i] = v.d;
    isl[i] = v.s;
    ordy[i] = v.rdy;
    @(negedge clk);
    chk($sformatf("%s out_valid", tag), 32'(ov[i]), 32'(v.e_ov));
    chk($sformatf("%s in_ready", tag), 32'(ir[i]), 32'(v.e_ir));
    chk($sformatf("%s out_ctrl", tag), 32'(oc[i]), 32'(v.e_oc));
    chk($sformatf("%s out_data", tag), 32'(od[i]), 32'(v.e_od));
    chk($sformatf("%s out_sel", tag), 32'(os[i]), 32'(v.e_os));
    chk($sformatf("%s occupancy", tag), 32'(occ[i]), 32'(v.e_occ));
    @(posedge clk);
    #1;
  endtask

  vec_t t1 [23];
  vec_t t0 [6];

  // Reference model: each stage is a FIFO of held entries {c,d,s}.
  logic [CW+DW+SW-1:0] mq [2][3];
  int cnt [2];

  task automatic model_step(input int i);
    int n;
    logic e_ov, e_ir, out_f, in_f;
    logic [CW+DW+SW-1:0] fr;
    n    = cnt[i];
    fr   = mq[i][0];
    e_ov = (n > 0);
    e_ir = (i == 1) ? (n < 2) : (n == 0 || ordy[i]);
    chk($sformatf("rnd%0d out_valid", i), 32'(ov[i]), 32'(e_ov));
    chk($sformatf("rnd%0d in_ready", i), 32'(ir[i]), 32'(e_ir));
    chk($sformatf("rnd%0d occupancy", i), 32'(occ[i]), 32'(n));
    chk($sformatf("rnd%0d out_ctrl", i), 32'(oc[i]),
        e_ov ? 32'(fr[CW+DW+SW-1 -: CW]) : 32'd0);
    if (e_ov) begin
      chk($sformatf("rnd%0d out_data", i), 32'(od[i]),
          32'(fr[DW+SW-1 -: DW]));
      chk($sformatf("rnd%0d out_sel", i), 32'(os[i]),
          32'(fr[SW-1:0]));
    end
    out_f = e_ov && ordy[i];
    in_f  = iv[i] && e_ir;
    if (fl) begin
      cnt[i] = 0;
    end else begin
      if (out_f) begin
        mq[i][0] = mq[i][1];
        mq[i][1] = mq[i][2];
        cnt[i]   = cnt[i] - 1;
      end
      if (in_f) begin
        mq[i][cnt[i]] = {ic[i], idt[i], isl[i]};
        cnt[i]        = cnt[i] + 1;
      end
    end
  endtask

  initial begin
    //              r f v  c      d         s rdy ov ir oc     od        os occ
    t1[0]  = mk(0,0,1,8'h81,16'h1111,3'd1,1, 0,1,8'h00,16'h0000,3'd0,2'd0);
    t1[1]  = mk(0,0,1,8'h81,16'h2222,3'd2,1, 1,1,8'h81,16'h1111,3'd1,2'd1);
    t1[2]  = mk(0,0,1,8'h81,16'h3333,3'd3,1, 1,1,8'h81,16'h2222,3'd2,2'd1);
    t1[3]  = mk(0,0,1,8'h81,16'h4444,3'd4,1, 1,1,8'h81,16'h3333,3'd3,2'd1);
    t1[4]  = mk(0,0,0,8'h00,16'h0000,3'd0,1, 1,1,8'h81,16'h4444,3'd4,2'd1);
    t1[5]  = mk(0,0,0,8'h00,16'h0000,3'd0,1, 0,1,8'h00,16'h4444,3'd4,2'd0);
    t1[6]  = mk(0,0,1,8'h5A,16'hAAAA,3'd5,0, 0,1,8'h00,16'h4444,3'd4,2'd0);
    t1[7]  = mk(0,0,1,8'h3C,16'hBBBB,3'd6,0, 1,1,8'h5A,16'hAAAA,3'd5,2'd1);
    t1[8]  = mk(0,0,0,8'h00,16'h0000,3'd0,0, 1,0,8'h5A,16'hAAAA,3'd5,2'd2);
    t1[9]  = mk(0,0,0,8'h00,16'h0000,3'd0,1, 1,0,8'h5A,16'hAAAA,3'd5,2'd2);
    t1[10] = mk(0,0,0,8'h00,16'h0000,3'd0,1, 1,1,8'h3C,16'hBBBB,3'd6,2'd1);
    t1[11] = mk(0,0,0,8'h00,16'h0000,3'd0,0, 0,1,8'h00,16'hBBBB,3'd6,2'd0);
    t1[12] = mk(0,0,1,8'h11,16'h1234,3'd7,0, 0,1,8'h00,16'hBBBB,3'd6,2'd0);
    t1[13] = mk(0,0,1,8'h22,16'h5678,3'd1,0, 1,1,8'h11,16'h1234,3'd7,2'd1);
    t1[14] = mk(0,1,1,8'h33,16'hCCCC,3'd4,0, 1,0,8'h11,16'h1234,3'd7,2'd2);
    t1[15] = mk(0,0,0,8'h00,16'h0000,3'd0,1, 0,1,8'h00,16'h1234,3'd7,2'd0);
    t1[16] = mk(0,0,0,8'h00,16'h0000,3'd0,1, 0,1,8'h00,16'h1234,3'd7,2'd0);
    t1[17] = mk(0,0,1,8'h44,16'h9999,3'd2,0, 0,1,8'h00,16'h1234,3'd7,2'd0);
    t1[18] = mk(0,0,1,8'h55,16'h7777,3'd3,0, 1,1,8'h44,16'h9999,3'd2,2'd1);
    t1[19] = mk(1,1,0,8'h00,16'h0000,3'd0,0, 1,0,8'h44,16'h9999,3'd2,2'd2);
    t1[20] = mk(0,0,1,8'h66,16'h5555,3'd5,1, 0,1,8'h00,16'h0000,3'd0,2'd0);
    t1[21] = mk(0,0,0,8'h00,16'h0000,3'd0,1, 1,1,8'h66,16'h5555,3'd5,2'd1);
    t1[22] = mk(0,0,0,8'h00,16'h0000,3'd0,1, 0,1,8'h00,16'h5555,3'd5,2'd0);

    t0[0] = mk(0,0,1,8'h0F,16'hA001,3'd1,1, 0,1,8'h00,16'h0000,3'd0,2'd0);
    t0[1] = mk(0,0,1,8'h0F,16'hA002,3'd2,0, 1,0,8'h0F,16'hA001,3'd1,2'd1);
    t0[2] = mk(0,0,1,8'h0F,16'hA002,3'd2,1, 1,1,8'h0F,16'hA001,3'd1,2'd1);
    t0[3] = mk(0,0,1,8'h0F,16'hA003,3'd3,1, 1,1,8'h0F,16'hA002,3'd2,2'd1);
    t0[4] = mk(0,0,0,8'h00,16'h0000,3'd0,1, 1,1,8'h0F,16'hA003,3'd3,2'd1);
    t0[5] = mk(0,0,0,8'h00,16'h0000,3'd0,0, 0,1,8'h00,16'hA003,3'd3,2'd0);

    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b0;
      ic[i] = '0;   idt[i] = '0; isl[i] = '0;
    end
    rst = 1'b1;
    fl  = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int k = 0; k < 23; k++)
      apply(1, t1[k], $sformatf("skid1 row%0d", k));
    for (int k = 0; k < 6; k++)
      apply(0, t0[k], $sformatf("skid0 row%0d", k));

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cnt[0] = 0;
    cnt[1] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      fl = ($urandom_range(0, 99) < 3);
      for (int i = 0; i < 2; i++) begin
        iv[i]   = ($urandom_range(0, 9) < 7);
        ordy[i] = ($urandom_range(0, 9) < 6);
        ic[i]   = CW'($urandom);
        idt[i]  = DW'($urandom);
        isl[i]  = SW'($urandom);
      end
      @(negedge clk);
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
